// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module : keypad_pkg
// Brief  : Shared types, sizes and row-decode helpers for the keypad scanner.
// Rev    : 1.0
// ============================================================================
package keypad_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic [2:0] low_row_count(input logic [NUM_ROWS-1:0] rows_n);
        logic [2:0] n;
        n = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            n = n + {2'b00, ~rows_n[r]};
        end
        return n;
    endfunction

    // Lowest-numbered low row; only meaningful when exactly one row is low.
    function automatic logic [1:0] low_row_idx(input logic [NUM_ROWS-1:0] rows_n);
        logic [1:0] idx;
        idx = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rows_n[r]) begin
                idx = r[1:0];
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module : keypad_sync
// Brief  : Parameterized-width 2-flop synchronizer, async active-low reset.
// Rev    : 1.0
// ============================================================================
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module : keypad_scanner
// Brief  : 4x4 matrix keypad scanner with debounce; optional auto-repeat
//          enabled by defining KEYPAD_AUTOREPEAT_EN.
// Rev    : 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int DEB_CYC     = 20000,
    parameter int REPEAT_DLY  = 5000000,
    parameter int REPEAT_RATE = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_ROWS-1:0]   row_n,
    output logic [NUM_COLS-1:0]   col_n,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held,
    output logic                  multi_err
);

    localparam int c_div_w = $clog2(SCAN_DIV);
    localparam int c_deb_w = $clog2(DEB_CYC);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYC - 1);

    generate
        if (SCAN_DIV < 4) begin : g_bad_scan_div
            $error("keypad_scanner: SCAN_DIV must be at least 4");
        end
        if (DEB_CYC < 2) begin : g_bad_deb_cyc
            $error("keypad_scanner: DEB_CYC must be at least 2");
        end
        if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
            $error("keypad_scanner: REPEAT_DLY and REPEAT_RATE must be positive");
        end
    endgenerate

    state_t                r_state,     w_state_nxt;
    logic [1:0]            r_col,       w_col_nxt;
    logic [c_div_w-1:0]    r_div,       w_div_nxt;
    logic [c_deb_w-1:0]    r_cnt,       w_cnt_nxt;
    logic [NUM_ROWS-1:0]   r_pat,       w_pat_nxt;
    logic [KEY_CODE_W-1:0] r_cap,       w_cap_nxt;
    logic [KEY_CODE_W-1:0] r_code,      w_code_nxt;
    logic                  r_key_valid, w_valid_nxt;
    logic                  r_multi_err, w_multi_nxt;

    logic [NUM_ROWS-1:0]   w_rows;
    logic [2:0]            w_low_cnt;
    logic [1:0]            w_row_idx;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int c_rep_w   = (c_rep_max > 1) ? $clog2(c_rep_max) : 1;
    localparam logic [c_rep_w-1:0] c_dly_last  = c_rep_w'(REPEAT_DLY - 1);
    localparam logic [c_rep_w-1:0] c_rate_last = c_rep_w'(REPEAT_RATE - 1);

    logic [c_rep_w-1:0] r_rep,       w_rep_nxt;
    logic               r_rep_phase, w_rep_phase_nxt;
    logic               w_rep_hit;

    // Phase 0 waits out the initial delay, phase 1 counts the repeat period.
    assign w_rep_hit = r_rep_phase ? (r_rep == c_rate_last) : (r_rep == c_dly_last);
`endif

    keypad_sync #(
        .WIDTH (NUM_ROWS)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .i_d (row_n),
        .o_q (w_rows)
    );

    assign w_low_cnt = low_row_count(w_rows);
    assign w_row_idx = low_row_idx(w_rows);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SCAN;
            r_col       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_pat       <= '0;
            r_cap       <= '0;
            r_code      <= '0;
            r_key_valid <= 1'b0;
            r_multi_err <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep       <= '0;
            r_rep_phase <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_div       <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pat       <= w_pat_nxt;
            r_cap       <= w_cap_nxt;
            r_code      <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_multi_err <= w_multi_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep       <= w_rep_nxt;
            r_rep_phase <= w_rep_phase_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_pat_nxt   = r_pat;
        w_cap_nxt   = r_cap;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        w_multi_nxt = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_nxt       = r_rep;
        w_rep_phase_nxt = r_rep_phase;
`endif
        unique case (r_state)
            SCAN: begin
                if (r_div == c_div_last) begin
                    w_div_nxt = '0;
                    if (w_low_cnt == 3'd1) begin
                        w_state_nxt = DEBOUNCE;
                        w_pat_nxt   = w_rows;
                        w_cap_nxt   = {w_row_idx, r_col};
                        w_cnt_nxt   = '0;
                    end else begin
                        w_col_nxt   = r_col + 2'd1;
                        w_multi_nxt = (w_low_cnt > 3'd1);
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (w_rows != r_pat) begin
                    // Bounce: rescan the same column from the start of its dwell.
                    w_state_nxt = SCAN;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = HELD;
                    w_code_nxt  = r_cap;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    w_rep_nxt       = '0;
                    w_rep_phase_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (&w_rows) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (w_rep_hit) begin
                    w_valid_nxt     = 1'b1;
                    w_rep_nxt       = '0;
                    w_rep_phase_nxt = 1'b1;
                end else begin
                    w_rep_nxt = r_rep + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!(&w_rows)) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = SCAN;
                    w_col_nxt   = r_col + 2'd1;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    assign col_n     = ~(4'b0001 << r_col);
    assign key_code  = r_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == HELD) || (r_state == RELEASE);
    assign multi_err = r_multi_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_scanner
// Brief  : Self-checking bench for keypad_scanner with a keypad matrix model.
// Rev    : 1.0
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV    = 4;
    localparam int DEB_CYC     = 8;
    localparam int REPEAT_DLY  = 16;
    localparam int REPEAT_RATE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_err;

    logic [15:0] keys = '0;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_valid = 0;
    int n_multi = 0;
    int valid_cycs[$];
    int multi_cycs[$];
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } press_vec_t;

    press_vec_t tbl[6];

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEB_CYC     (DEB_CYC),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Row r is pulled low only through a pressed key on a driven column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (key_valid) begin
                n_valid++;
                valid_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_valid: actual key_code=%0h required no pulse", key_code);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("key_code", 32'(key_code), 32'(mon_exp));
                end
            end
            if (multi_err) begin
                n_multi++;
                multi_cycs.push_back(cyc);
            end
        end
    end

    task automatic wait_valid(input int base, input int max_cyc, output bit got);
        got = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge clk); #2;
            if (n_valid > base) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int max_cyc, output bit got);
        got = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge clk); #2;
            if (!key_held) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic press_release(input int r, input int c, input logic [3:0] code);
        int base;
        bit got;
        base = n_valid;
        exp_q.push_back(code);
        keys = '0;
        keys[r*4+c] = 1'b1;
        wait_valid(base, 200, got);
        check($sformatf("valid_seen_%0d%0d", r, c), 32'(got), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        check($sformatf("held_%0d%0d", r, c), 32'(key_held), 32'd1);
        keys = '0;
        wait_held_low(100, got);
        check($sformatf("held_drop_%0d%0d", r, c), 32'(got), 32'd1);
        check($sformatf("one_pulse_%0d%0d", r, c), 32'(n_valid - base), 32'd1);
        repeat (5) @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  m0;
        int  v0;
        int  bad_int;
        bit  got;
        bit  held_seen;

        tbl[0] = '{r: 2, c: 1, code: 4'h9};
        tbl[1] = '{r: 0, c: 0, code: 4'h0};
        tbl[2] = '{r: 3, c: 3, code: 4'hF};
        tbl[3] = '{r: 0, c: 2, code: 4'h2};
        tbl[4] = '{r: 3, c: 0, code: 4'hC};
        tbl[5] = '{r: 1, c: 3, code: 4'h7};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_col_n",     32'(col_n),     32'hE);
        check("rst_key_code",  32'(key_code),  32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held",  32'(key_held),  32'h0);
        check("rst_multi_err", 32'(multi_err), 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        for (int i = 0; i < 6; i++) begin
            press_release(tbl[i].r, tbl[i].c, tbl[i].code);
        end

        // Bouncing contact on (1,3), then stable
        base = n_valid;
        exp_q.push_back(4'h7);
        for (int k = 0; k < 10; k++) begin
            keys = '0;
            if (k % 2 == 0) keys[1*4+3] = 1'b1;
            repeat (3) @(posedge clk);
            #2;
        end
        keys = '0;
        keys[1*4+3] = 1'b1;
        wait_valid(base, 200, got);
        check("bounce_valid_seen", 32'(got), 32'd1);
        repeat (4) @(posedge clk);
        #2;
        keys = '0;
        wait_held_low(100, got);
        check("bounce_held_drop", 32'(got), 32'd1);
        check("bounce_one_pulse", 32'(n_valid - base), 32'd1);

        // Two keys in column 2
        repeat (10) @(posedge clk);
        #2;
        base = n_valid;
        m0 = n_multi;
        held_seen = 1'b0;
        keys = '0;
        keys[0*4+2] = 1'b1;
        keys[3*4+2] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #2;
            if (key_held) held_seen = 1'b1;
        end
        keys = '0;
        check("multi_no_held", 32'(held_seen), 32'd0);
        check("multi_no_valid", 32'(n_valid - base), 32'd0);
        check("multi_enough_pulses", 32'(n_multi - m0 >= 5), 32'd1);
        bad_int = 0;
        for (int k = m0 + 1; k < n_multi; k++) begin
            if (multi_cycs[k] - multi_cycs[k-1] != 16) bad_int++;
        end
        check("multi_period", 32'(bad_int), 32'd0);
        repeat (20) @(posedge clk);
        #2;

        // Short release glitch, then full release
        base = n_valid;
        exp_q.push_back(4'h9);
        keys = '0;
        keys[2*4+1] = 1'b1;
        wait_valid(base, 200, got);
        check("glitch_valid_seen", 32'(got), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        keys = '0;
        repeat (5) @(posedge clk);
        #2;
        keys[2*4+1] = 1'b1;
        held_seen = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #2;
            if (!key_held) held_seen = 1'b0;
        end
        check("glitch_held_stays", 32'(held_seen), 32'd1);
        check("glitch_no_new_valid", 32'(n_valid - base), 32'd1);
        keys = '0;
        wait_held_low(100, got);
        check("glitch_full_release", 32'(got), 32'd1);
        repeat (10) @(posedge clk);
        #2;

        // 40-cycle hold: repeats only with auto-repeat
        base = n_valid;
        exp_q.push_back(4'h5);
`ifdef KEYPAD_AUTOREPEAT_EN
        repeat (4) exp_q.push_back(4'h5);
`endif
        keys = '0;
        keys[1*4+1] = 1'b1;
        wait_valid(base, 200, got);
        check("hold_valid_seen", 32'(got), 32'd1);
        v0 = got ? valid_cycs[base] : 0;
        repeat (41) @(posedge clk);
        #2;
        keys = '0;
        wait_held_low(100, got);
        check("hold_held_drop", 32'(got), 32'd1);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hold_pulse_count", 32'(n_valid - base), 32'd5);
        if (n_valid - base == 5) begin
            check("rep_off1", 32'(valid_cycs[base+1] - v0), 32'd16);
            check("rep_off2", 32'(valid_cycs[base+2] - v0), 32'd24);
            check("rep_off3", 32'(valid_cycs[base+3] - v0), 32'd32);
            check("rep_off4", 32'(valid_cycs[base+4] - v0), 32'd40);
        end
`else
        check("hold_pulse_count", 32'(n_valid - base), 32'd1);
`endif
        repeat (10) @(posedge clk);
        #2;

        // Reset while held, key still pressed afterwards
        base = n_valid;
        exp_q.push_back(4'h9);
        keys = '0;
        keys[2*4+1] = 1'b1;
        wait_valid(base, 200, got);
        check("rsth_valid_seen", 32'(got), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        check("rsth_held_before", 32'(key_held), 32'd1);
        rst = 1'b0;
        #1;
        check("rsth_col_n",     32'(col_n),     32'hE);
        check("rsth_key_code",  32'(key_code),  32'h0);
        check("rsth_key_held",  32'(key_held),  32'h0);
        check("rsth_key_valid", 32'(key_valid), 32'h0);
        check("rsth_multi_err", 32'(multi_err), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        base = n_valid;
        exp_q.push_back(4'h9);
        rst = 1'b1;
        wait_valid(base, 200, got);
        check("rsth_redetect", 32'(got), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        keys = '0;
        wait_held_low(100, got);
        check("rsth_release", 32'(got), 32'd1);
        repeat (10) @(posedge clk);
        #2;

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
